pixel_plotter: RTL and testbench
================================

Name: pixel_plotter

Overview:
Consumer end of the drawing-primitive coordinate stream. Accepts (valid, x, y) points and throttles the primitive through its clk_en input. Clips each point to the panel and converts it to a linear framebuffer address. Buffers points in a small FIFO and issues req/ack writes of a latched colour to the framebuffer/display write port. Sits between the GPU primitives and the framebuffer arbiter.

Parameters:
DATA_WIDTH, 8, coordinate width (matches primitives)
H_RES, 240, panel width in pixels
V_RES, 240, panel height in pixels
ADDR_WIDTH, 16, framebuffer address width (must satisfy H_RES*V_RES <= 2**ADDR_WIDTH)
COLOR_WIDTH, 16, pixel colour width (RGB565)
FIFO_DEPTH, 4, point buffer entries (power of two, >= 4)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches colour, clears done, begins a primitive
color  in  COLOR_WIDTH  colour, sampled on start
clk_en_o  out  1  throttle to the primitive's clk_en
valid_i  in  1  point valid from the primitive
x_i  in  DATA_WIDTH  point x
y_i  in  DATA_WIDTH  point y
done_i  in  1  primitive completion pulse
wr_req  out  1  write request
wr_addr  out  ADDR_WIDTH  linear address y*H_RES+x
wr_data  out  COLOR_WIDTH  latched colour
wr_ack  in  1  write accepted (single-cycle pulse)
busy  out  1  high from start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: clk_en_o=0, wr_req=0, wr_addr=0, wr_data=0, busy=0, done=0. FIFO empty. State IDLE.
- Stage 1, registered, 1 cycle: on valid_i, compute in_range = (x_i < H_RES) && (y_i < V_RES), unsigned compare. Primitive underflow (e.g. x0-r wrapping to 0xF6) is therefore clipped. If in range, form addr = y_i*H_RES + x_i in ADDR_WIDTH bits. Stage 1 pushes the address to the FIFO one cycle after valid_i. Out-of-range points are dropped and never pushed.
- Throttle: the primitive emits valid up to 2 cycles after a clk_en it sampled, so 3 points can be in flight (2 at the primitive plus stage 1).
  - clk_en_o = busy && (FIFO_DEPTH - count - inflight) >= 3.
  - inflight = number of clk_en_o pulses issued in the last 2 cycles plus the stage-1 valid.
  - The FIFO must never overflow. An overflow push is dropped and, in simulation, flagged by an assertion.
- Write FSM:
  - IDLE: busy=0. On start, latch colour into wr_data, go to RUN.
  - RUN: if FIFO not empty and wr_req=0, load the head into wr_addr and assert wr_req. Hold wr_req and wr_addr stable until wr_ack. On wr_ack, pop the head; wr_req may reassert on the next cycle.
    - done_i sets a sticky done_pend.
    - When done_pend, stage 1 is empty, FIFO is empty and no wr_req is outstanding, go to DONE.
  - DONE: done=1 for one cycle, busy drops, clear done_pend, go to IDLE.
- Throughput: one write per 2 cycles with zero-wait ack (req cycle, then ack/pop cycle).
- Simultaneous push and pop in one cycle: count unchanged.
- done_i arriving while the FIFO still holds points: remaining points are written before done.
- start while busy: ignored.
- valid_i while in IDLE: ignored.
- reset_n asserted mid-operation: returns to IDLE at once and drops wr_req without waiting for ack. The FIFO and done_pend clear.
- Width rules: the product y*H_RES is computed at ADDR_WIDTH bits. No truncation occurs for legal parameters.

Optional Feature:
Macro PIXEL_PLOTTER_DEDUP_EN.
- Defined: stage 1 holds the last pushed address plus a last_valid flag (cleared on start). A point whose address equals the last pushed address is dropped. Octant-boundary duplicates (e.g. r=0, or x==y points) are written once only.
- Not defined: every in-range point is written, duplicates included.

Decomposition:
- Shared package gpu_pkg holds:
  - the state encoding constants (IDLE/RUN/DONE, one-hot like the other GPU blocks);
  - the H_RES/V_RES default constants;
  - the colour width constant.
- One natural sub-module: pixel_fifo, a synchronous FIFO with parameterised depth/width and count output, reused by other GPU blocks.

Test Plan:
- Reset mid-write: assert wr_req, hold wr_ack=0, pulse reset_n low -> wr_req=0 immediately; busy=0; next start works normally.
- Single point: start with color=16'hF800, then point (10,3), wr_ack the next cycle -> exactly one write, addr=730, data=F800; then done_i -> done pulses once; busy=0.
- Clipping: points (245,5), (5,240) and (0xF6,0x10) -> no writes; point (239,239) -> addr=57599.
- Back-pressure: hold wr_ack=0 for 50 cycles while driving a generator model that obeys clk_en_o -> no FIFO overflow; clk_en_o low when full; all points are later written in order.
- Circle r=0 at (100,100) from the primitive model (8 identical points):
  - without DEDUP_EN -> 8 writes of addr 24100;
  - with DEDUP_EN -> 1 write.
- done_i arriving with 3 points queued and wr_ack delayed 4 cycles each -> done asserts only after the 3rd ack.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: controller state encoding, panel defaults and pixel
// colour width. Used by the pixel plotter and the other drawing blocks.
package gpu_pkg;

  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 240;
  localparam int COLOR_W   = 16;

  // One-hot, matching the other GPU sequencing blocks.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } plot_state_e;

endpackage

// File: rtl/pixel_plotter_if.sv
// Framebuffer write port: req/ack handshake carrying a linear address and a
// colour. The plotter drives it through the master modport; the framebuffer
// arbiter answers through the slave modport.
interface pixel_plotter_if
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = COLOR_W
);

  logic                   wr_req;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [COLOR_WIDTH-1:0] wr_data;
  logic                   wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with occupancy count, shared by several GPU blocks.
// DEPTH must be a power of two so the pointers wrap on their own.
// A push while full with no simultaneous pop is dropped.
module pixel_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  overflow_push: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(push && full && !pop));

endmodule

// File: rtl/pixel_plotter.sv
// Pixel plotter: consumes (valid, x, y) points from a drawing primitive,
// clips them to the panel, converts them to linear framebuffer addresses,
// buffers them and writes the latched colour over a req/ack port.
// The primitive is paced through clk_en_o so the point FIFO cannot overflow.
// Optional build macro PIXEL_PLOTTER_DEDUP_EN: drop a point whose address
// equals the previously accepted one (octant-boundary duplicates).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; colour is latched on start
// RUN     | accepting points and writing them; leaves once drained
// DONE    | one-cycle done pulse, then back to IDLE
module pixel_plotter
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = COLOR_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [COLOR_WIDTH-1:0] color,
  output logic                   clk_en_o,
  input  logic                   valid_i,
  input  logic [DATA_WIDTH-1:0]  x_i,
  input  logic [DATA_WIDTH-1:0]  y_i,
  input  logic                   done_i,
  pixel_plotter_if.master        wr_if,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  plot_state_e            state_q, state_d;
  logic                   s1_valid;
  logic [ADDR_WIDTH-1:0]  s1_addr;
  logic                   en_d1, en_d2;
  logic                   done_pend;
  logic                   wr_req_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [COLOR_WIDTH-1:0] wr_data_q;
  logic                   fifo_empty, fifo_full, fifo_pop;
  logic [ADDR_WIDTH-1:0]  fifo_head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   in_range, accept;
  logic [ADDR_WIDTH-1:0]  addr_calc;
  logic [1:0]             inflight;

  // Unsigned compare, so primitive underflow (e.g. 0xF6) falls outside.
  assign in_range  = (int'(x_i) < H_RES) && (int'(y_i) < V_RES);
  assign addr_calc = ADDR_WIDTH'(y_i) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(x_i);

`ifdef PIXEL_PLOTTER_DEDUP_EN
  logic                  last_valid;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  is_dup;

  assign is_dup = last_valid && (last_addr == addr_calc);

  // Remember the last address taken into stage 1; forget it on a new primitive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_valid <= 1'b0;
      last_addr  <= '0;
    end else if (state_q == ST_IDLE && start) begin
      last_valid <= 1'b0;
    end else if (accept) begin
      last_valid <= 1'b1;
      last_addr  <= addr_calc;
    end
  end
`else
  logic is_dup;
  assign is_dup = 1'b0;
`endif

  assign accept = (state_q == ST_RUN) && valid_i && in_range && !is_dup;

  // Stage 1 register plus a two-deep history of issued enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      en_d1    <= 1'b0;
      en_d2    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_addr <= addr_calc;
      en_d1 <= clk_en_o;
      en_d2 <= en_d1;
    end
  end

  // Points that may still land: two enables at the primitive plus stage 1.
  assign inflight = {1'b0, en_d1} + {1'b0, en_d2} + {1'b0, s1_valid};
  assign clk_en_o = busy && !fifo_full &&
                    ((FIFO_DEPTH - int'(fifo_count) - int'(inflight)) >= 3);

  pixel_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (s1_valid),
    .din     (s1_addr),
    .pop     (fifo_pop),
    .dout    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign fifo_pop = wr_req_q && wr_if.wr_ack;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (done_pend && !s1_valid && fifo_empty && !wr_req_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write port: head is held in wr_addr until acked, then popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start) wr_data_q <= color;
      if (fifo_pop) begin
        wr_req_q <= 1'b0;
      end else if (state_q == ST_RUN && !wr_req_q && !fifo_empty) begin
        wr_req_q  <= 1'b1;
        wr_addr_q <= fifo_head;
      end
    end
  end

  // Sticky record of the primitive's completion until the queue drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                done_pend <= 1'b0;
    else if (state_q != ST_RUN)  done_pend <= 1'b0;
    else if (done_i)             done_pend <= 1'b1;
  end

  assign wr_if.wr_req  = wr_req_q;
  assign wr_if.wr_addr = wr_addr_q;
  assign wr_if.wr_data = wr_data_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Directed bench for pixel_plotter: a throttle-obeying point generator, an
// ack responder with programmable latency that logs every accepted write,
// and hand-computed expected addresses.
module tb_pixel_plotter;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] color = '0;
  logic        clk_en_o;
  logic        valid_i = 1'b0;
  logic [7:0]  x_i = '0;
  logic [7:0]  y_i = '0;
  logic        done_i = 1'b0;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  bit ack_en = 1'b1;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  logic [7:0]  pt_x[$];
  logic [7:0]  pt_y[$];

  pixel_plotter_if #(.ADDR_WIDTH(16), .COLOR_WIDTH(16)) wr_if ();

  pixel_plotter #(
    .DATA_WIDTH (8),
    .H_RES      (240),
    .V_RES      (240),
    .ADDR_WIDTH (16),
    .COLOR_WIDTH(16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .color    (color),
    .clk_en_o (clk_en_o),
    .valid_i  (valid_i),
    .x_i      (x_i),
    .y_i      (y_i),
    .done_i   (done_i),
    .wr_if    (wr_if),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < log_addr.size()) return 32'(log_addr[i]);
    return 32'hDEAD_BEEF;
  endfunction

  // Framebuffer responder: acks after ack_delay cycles of a pending request.
  initial begin
    wr_if.wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_if.wr_ack = 1'b0;
      if (!ack_en || wr_if.wr_req !== 1'b1) begin
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        wr_if.wr_ack = 1'b1;
        log_addr.push_back(wr_if.wr_addr);
        log_data.push_back(wr_if.wr_data);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    pt_x.delete();
    pt_y.delete();
  endtask

  task automatic add_pt(input logic [7:0] x, input logic [7:0] y);
    pt_x.push_back(x);
    pt_y.push_back(y);
  endtask

  task automatic do_start(input logic [15:0] c);
    @(negedge clk);
    start = 1'b1;
    color = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
  endtask

  // Primitive model: a clk_en seen in one cycle yields a point in the next.
  task automatic gen_points(input int budget);
    int idx = 0;
    bit en_prev = 1'b0;
    for (int c = 0; c < budget && idx < pt_x.size(); c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (en_prev) begin
        valid_i = 1'b1;
        x_i = pt_x[idx];
        y_i = pt_y[idx];
        idx++;
      end
      en_prev = clk_en_o;
    end
    @(negedge clk);
    valid_i = 1'b0;
    check("gen_all_points_sent", 32'(idx), 32'(pt_x.size()));
  endtask

  task automatic wait_done(input string tag, input int budget, input int exp_writes);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_writes_at_done"}, 32'(log_addr.size()), 32'(exp_writes));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] bp_exp[6];
    int bad;
    int exp_circle;
    bit seen;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_clk_en", 32'(clk_en_o), 32'd0);
    check("rst_wr_req", 32'(wr_if.wr_req), 32'd0);
    check("rst_wr_addr", 32'(wr_if.wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_if.wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // valid_i in IDLE is ignored, then a single point.
    clear_logs();
    valid_i = 1'b1; x_i = 8'd20; y_i = 8'd20;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_valid_no_req", 32'(wr_if.wr_req), 32'd0);
    check("idle_valid_no_busy", 32'(busy), 32'd0);
    do_start(16'hF800);
    check("single_busy", 32'(busy), 32'd1);
    add_pt(8'd10, 8'd3);
    gen_points(50);
    pulse_done();
    wait_done("single", 50, 1);
    check("single_addr", log_at(0), 32'd730);
    check("single_data", 32'(log_data.size() > 0 ? log_data[0] : 16'h0), 32'hF800);

    // Clipping, plus a start while busy that must not change the colour.
    clear_logs();
    do_start(16'h1234);
    add_pt(8'd245, 8'd5);
    add_pt(8'd5, 8'd240);
    add_pt(8'hF6, 8'h10);
    add_pt(8'd239, 8'd239);
    gen_points(60);
    do_start(16'hABCD);
    pulse_done();
    wait_done("clip", 60, 1);
    check("clip_addr", log_at(0), 32'd57599);
    check("clip_wr_data_held", 32'(wr_if.wr_data), 32'h1234);

    // r=0 circle: eight identical points at (100,100).
    clear_logs();
`ifdef PIXEL_PLOTTER_DEDUP_EN
    exp_circle = 1;
`else
    exp_circle = 8;
`endif
    do_start(16'h07E0);
    for (int i = 0; i < 8; i++) add_pt(8'd100, 8'd100);
    gen_points(100);
    pulse_done();
    wait_done("circle", 100, exp_circle);
    bad = 0;
    foreach (log_addr[i]) if (log_addr[i] !== 16'd24100) bad++;
    check("circle_addrs", 32'(bad), 32'd0);

    // Back-pressure: no acks for 50 cycles.
    clear_logs();
    ack_en = 1'b0;
    bp_exp = '{16'd0, 16'd1, 16'd240, 16'd482, 16'd12100, 16'd48017};
    do_start(16'h001F);
    add_pt(8'd0, 8'd0);
    add_pt(8'd1, 8'd0);
    add_pt(8'd0, 8'd1);
    add_pt(8'd2, 8'd2);
    add_pt(8'd100, 8'd50);
    add_pt(8'd17, 8'd200);
    fork
      gen_points(300);
      begin
        repeat (50) @(negedge clk);
        check("bp_clk_en_low", 32'(clk_en_o), 32'd0);
        check("bp_req_pending", 32'(wr_if.wr_req), 32'd1);
        check("bp_no_writes", 32'(log_addr.size()), 32'd0);
        ack_en = 1'b1;
      end
    join
    pulse_done();
    wait_done("bp", 100, 6);
    for (int i = 0; i < 6; i++) check($sformatf("bp_addr%0d", i), log_at(i), 32'(bp_exp[i]));

    // done_i with points still queued and slow acks.
    clear_logs();
    ack_delay = 4;
    do_start(16'h5555);
    add_pt(8'd1, 8'd1);
    add_pt(8'd2, 8'd1);
    add_pt(8'd3, 8'd1);
    gen_points(100);
    pulse_done();
    check("late_done_queued", 32'(log_addr.size() < 3), 32'd1);
    wait_done("late_done", 200, 3);
    check("late_addr2", log_at(2), 32'd243);
    ack_delay = 0;

    // Reset while a write is outstanding.
    clear_logs();
    ack_en = 1'b0;
    do_start(16'h001F);
    add_pt(8'd5, 8'd5);
    gen_points(30);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (wr_if.wr_req === 1'b1) seen = 1'b1;
    end
    check("rstmid_req_seen", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_wr_req", 32'(wr_if.wr_req), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_clk_en", 32'(clk_en_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_en = 1'b1;
    clear_logs();
    do_start(16'hF800);
    add_pt(8'd10, 8'd3);
    gen_points(50);
    pulse_done();
    wait_done("post_rst", 50, 1);
    check("post_rst_addr", log_at(0), 32'd730);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
